hazard_controller: RTL



---
 rtl/hazard_controller.sv | 77 +++++++
 1 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/flush sequencing for load-use, taken branches and multi-cycle MDU ops
module hazard_controller #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_2,
    input  logic [4:0]       RS2_2,
    input  logic             Use_RS1_2,
    input  logic             Use_RS2_2,
    input  logic [4:0]       RD_3,
    input  logic             Mem_Read_3,
    input  logic             MDU_Op_3,
    input  logic             Branch_Taken_3,
    input  logic             MDU_Done,
    output logic             MDU_Start,
    output logic             Stall_PC,
    output logic             Stall_IFID,
    output logic             Stall_IDEX,
    output logic             Flush_IFID,
    output logic             Flush_IDEX,
    output logic             Flush_EXMEM,
    output logic             MDU_Error,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    typedef enum logic {RUN, MDU_BUSY} state_t;
    state_t           state;
    logic [TW-1:0]    timer;
    logic             err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             load_use, timeout, hold, br, mdu, lu;
    // Priority decode: branch kills ID, then MDU launch, then load-use bubble; busy holds until done or watchdog
    always_comb begin
        load_use = Mem_Read_3 && RD_3 != 5'd0 &&
                   ((Use_RS1_2 && RS1_2 == RD_3) || (Use_RS2_2 && RS2_2 == RD_3));
        timeout  = timer == T_LAST;
        hold     = state == MDU_BUSY && !MDU_Done && !timeout;
        br       = state == RUN && Branch_Taken_3;
        mdu      = state == RUN && !Branch_Taken_3 && MDU_Op_3;
        lu       = state == RUN && !Branch_Taken_3 && !MDU_Op_3 && load_use;
    end
    assign MDU_Start   = !rst && mdu;
    assign Stall_PC    = !rst && (mdu || lu || hold);
    assign Stall_IFID  = !rst && (mdu || lu || hold);
    assign Stall_IDEX  = !rst && (mdu || hold);
    assign Flush_IFID  = !rst && br;
    assign Flush_IDEX  = !rst && (br || lu);
    assign Flush_EXMEM = !rst && (mdu || hold);
    assign MDU_Error   = !rst && err;
    assign Stall_Count = rst ? '0 : stall_cnt;
    assign Flush_Count = rst ? '0 : flush_cnt;
    // FSM, watchdog timer, sticky error and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            timer     <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mdu) begin
                state <= MDU_BUSY;
                timer <= '0;
            end else if (state == MDU_BUSY) begin
                if (MDU_Done || timeout) state <= RUN;
                if (timeout && !MDU_Done) err <= 1'b1;
                timer <= timer + 1'b1;
            end
            if ((mdu || lu || hold) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (br && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule
